// File: rtl/midi_voice_alloc.sv
// -----------------------------------------------------------------------------
// midi_voice_alloc
// Central polyphonic voice allocator. Takes 24-bit MIDI messages from the
// receiver, decides which wave generator plays each note-on (retrigger of a
// sounding note, lowest free voice, or steal of the least-recently-assigned
// voice) and drives per-voice gate, note number and load strobe.
//
// Ports
//   CLK           system clock, all logic on posedge
//   RST_N         asynchronous active-low reset
//   MIDI_MSG      {status, data1, data2}, sampled when MIDI_MSG_RDY=1
//   MIDI_MSG_RDY  single-cycle message strobe
//   BUSY          scheduler is working on a message (FSM not in IDLE)
//   OVERFLOW      one-cycle pulse: message dropped, pending buffer full
//   STEAL         one-cycle pulse alongside a VOICE_LOAD caused by a steal
//   VOICE_GATE    per-voice note-on level
//   VOICE_LOAD    one-hot one-cycle strobe: voice takes its VOICE_NOTE
//   VOICE_NOTE    per-voice note number, voice i at [8i+7:8i]
// -----------------------------------------------------------------------------
module midi_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int IDXW       = $clog2(NUM_VOICES)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [23:0]             MIDI_MSG,
    input  logic                    MIDI_MSG_RDY,
    output logic                    BUSY,
    output logic                    OVERFLOW,
    output logic                    STEAL,
    output logic [NUM_VOICES-1:0]   VOICE_GATE,
    output logic [NUM_VOICES-1:0]   VOICE_LOAD,
    output logic [8*NUM_VOICES-1:0] VOICE_NOTE
);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_VOICES - 1);

    state_t          state;
    logic            pend_valid;
    logic [23:0]     pend_msg;
    logic [23:0]     work_msg;
    logic [IDXW-1:0] idx;

    // Scan results for the message in the work register.
    logic            match_found;
    logic [IDXW-1:0] match_idx;
    logic            free_found;
    logic [IDXW-1:0] free_idx;
    logic [IDXW-1:0] oldest_idx;

    logic [7:0]      note_q [NUM_VOICES];
    logic [IDXW-1:0] rank_q [NUM_VOICES];   // 0 = most recently assigned

    logic            take;
    logic [7:0]      status, data1, data2;
    logic            is_note_on, is_note_off, is_all_off;
    logic [IDXW-1:0] target;
    logic [IDXW-1:0] target_rank;
    logic            is_steal;

    // The work register empties the pending slot on this edge, so a new
    // strobe arriving now can be captured without overflow.
    assign take = (state == IDLE) && pend_valid;

    // Only channel 0 is handled; anything unrecognised still walks the
    // full SCAN/COMMIT sequence so latency stays fixed.
    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        status      = work_msg[23:16];
        data1       = work_msg[15:8];
        data2       = work_msg[7:0];
        is_note_on  = (status == 8'h90) && (data2 != 8'h00);
        is_note_off = (status == 8'h80) || ((status == 8'h90) && (data2 == 8'h00));
        is_all_off  = (status == 8'hB0) && (data1 == 8'h7B);
        is_steal    = !match_found && !free_found;
        target      = match_found ? match_idx : (free_found ? free_idx : oldest_idx);
        target_rank = rank_q[target];
    end

    always_comb begin
        VOICE_NOTE = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            VOICE_NOTE[8*i +: 8] = note_q[i];
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            pend_valid  <= 1'b0;
            pend_msg    <= '0;
            work_msg    <= '0;
            idx         <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            oldest_idx  <= '0;
            BUSY        <= 1'b0;
            OVERFLOW    <= 1'b0;
            STEAL       <= 1'b0;
            VOICE_GATE  <= '0;
            VOICE_LOAD  <= '0;
            // NOTE: the per-voice arrays are a handful of flops, not a RAM,
            // and must reset: notes to 0 and ranks to a valid permutation.
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                rank_q[i] <= IDXW'(i);
            end
        end else begin
            OVERFLOW   <= 1'b0;
            STEAL      <= 1'b0;
            VOICE_LOAD <= '0;

            if (MIDI_MSG_RDY) begin
                if (!pend_valid || take) begin
                    pend_msg   <= MIDI_MSG;
                    pend_valid <= 1'b1;
                end else begin
                    OVERFLOW <= 1'b1;
                end
            end else if (take) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        work_msg    <= pend_msg;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        BUSY        <= 1'b1;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (!match_found && VOICE_GATE[idx] && (note_q[idx] == data1)) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!free_found && !VOICE_GATE[idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (rank_q[idx] == LAST_IDX) begin
                        oldest_idx <= idx;
                    end
                    if (idx == LAST_IDX) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    if (is_note_on) begin
                        VOICE_GATE[target] <= 1'b1;
                        VOICE_LOAD[target] <= 1'b1;
                        note_q[target]     <= data1;
                        STEAL              <= is_steal;
                        // Move target to the front; everything newer than
                        // it ages by one, keeping ranks a permutation.
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDXW'(i) == target) begin
                                rank_q[i] <= '0;
                            end else if (rank_q[i] < target_rank) begin
                                rank_q[i] <= rank_q[i] + IDXW'(1);
                            end
                        end
                    end else if (is_note_off) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (VOICE_GATE[i] && (note_q[i] == data1)) begin
                                VOICE_GATE[i] <= 1'b0;
                            end
                        end
                    end else if (is_all_off) begin
                        VOICE_GATE <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// -----------------------------------------------------------------------------
// tb_midi_voice_alloc
// Self-checking bench for midi_voice_alloc (NUM_VOICES=4). A behavioural
// model (gate/note arrays plus an LRU queue ordered newest-first, and a
// message scheduler counting edges to commit) predicts every output; one
// process compares DUT against it on every falling clock edge. Directed
// vectors also carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_midi_voice_alloc;

    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic [23:0]    MIDI_MSG = '0;
    logic           MIDI_MSG_RDY = 1'b0;
    logic           BUSY, OVERFLOW, STEAL;
    logic [N-1:0]   VOICE_GATE, VOICE_LOAD;
    logic [8*N-1:0] VOICE_NOTE;

    midi_voice_alloc #(.NUM_VOICES(N)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .MIDI_MSG     (MIDI_MSG),
        .MIDI_MSG_RDY (MIDI_MSG_RDY),
        .BUSY         (BUSY),
        .OVERFLOW     (OVERFLOW),
        .STEAL        (STEAL),
        .VOICE_GATE   (VOICE_GATE),
        .VOICE_LOAD   (VOICE_LOAD),
        .VOICE_NOTE   (VOICE_NOTE)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_gate [N];
    logic [7:0]  m_note [N];
    int          m_lru [$];          // voice indices, newest first
    logic [N-1:0] m_load;
    bit          m_steal, m_ovf;
    bit          m_pend_valid, m_work_active;
    logic [23:0] m_pend, m_work;
    int          m_remain;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_gate[i] = 1'b0;
            m_note[i] = 8'h00;
        end
        m_lru.delete();
        for (int i = 0; i < N; i++) m_lru.push_back(i);
        m_load = '0;
        m_steal = 1'b0;
        m_ovf = 1'b0;
        m_pend_valid = 1'b0;
        m_work_active = 1'b0;
        m_pend = '0;
        m_work = '0;
        m_remain = 0;
    endtask

    task automatic model_apply(input logic [23:0] m);
        logic [7:0] st, d1, d2;
        int t;
        st = m[23:16];
        d1 = m[15:8];
        d2 = m[7:0];
        if (st == 8'h90 && d2 != 8'h00) begin
            t = -1;
            for (int i = 0; i < N; i++)
                if (t < 0 && m_gate[i] && m_note[i] == d1) t = i;
            for (int i = 0; i < N; i++)
                if (t < 0 && !m_gate[i]) t = i;
            if (t < 0) begin
                t = m_lru[$];
                m_steal = 1'b1;
            end
            m_gate[t] = 1'b1;
            m_note[t] = d1;
            m_load[t] = 1'b1;
            for (int k = 0; k < m_lru.size(); k++) begin
                if (m_lru[k] == t) begin
                    m_lru.delete(k);
                    break;
                end
            end
            m_lru.push_front(t);
        end else if (st == 8'h80 || (st == 8'h90 && d2 == 8'h00)) begin
            for (int i = 0; i < N; i++)
                if (m_gate[i] && m_note[i] == d1) m_gate[i] = 1'b0;
        end else if (st == 8'hB0 && d1 == 8'h7B) begin
            for (int i = 0; i < N; i++) m_gate[i] = 1'b0;
        end
    endtask

    // One message occupies the scheduler for N+2 edges: the take edge,
    // N scan edges, and the commit edge.
    task automatic model_step(input logic rdy, input logic [23:0] msg);
        bit take;
        m_load = '0;
        m_steal = 1'b0;
        m_ovf = 1'b0;
        take = !m_work_active && m_pend_valid;
        if (m_work_active) begin
            m_remain--;
            if (m_remain == 0) begin
                model_apply(m_work);
                m_work_active = 1'b0;
            end
        end
        if (take) begin
            m_work = m_pend;
            m_work_active = 1'b1;
            m_remain = N + 1;
        end
        if (rdy) begin
            if (!m_pend_valid || take) begin
                m_pend = msg;
                m_pend_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (take) begin
            m_pend_valid = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) model_reset();
            else model_step(MIDI_MSG_RDY, MIDI_MSG);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [N-1:0]   exp_gate;
        logic [8*N-1:0] exp_note;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                exp_gate[i] = m_gate[i];
                exp_note[8*i +: 8] = m_note[i];
            end
            check("model_busy",     BUSY,       m_work_active);
            check("model_overflow", OVERFLOW,   m_ovf);
            check("model_steal",    STEAL,      m_steal);
            check("model_gate",     VOICE_GATE, exp_gate);
            check("model_load",     VOICE_LOAD, m_load);
            check("model_note",     VOICE_NOTE, exp_note);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Returns on the falling edge just after the capture edge E0.
    task automatic send(input logic [23:0] m);
        @(negedge CLK);
        MIDI_MSG = m;
        MIDI_MSG_RDY = 1'b1;
        @(negedge CLK);
        MIDI_MSG_RDY = 1'b0;
    endtask

    // Sends a note-on and checks the commit cycle against literals.
    task automatic note_on(input string name, input logic [23:0] m, input logic [N-1:0] load,
                           input logic steal, input logic [N-1:0] gate, input logic [8*N-1:0] notes);
        send(m);
        tick(N + 2);
        check({name, "_load"},  VOICE_LOAD, load);
        check({name, "_steal"}, STEAL,      steal);
        check({name, "_gate"},  VOICE_GATE, gate);
        check({name, "_note"},  VOICE_NOTE, notes);
        tick(1);
        check({name, "_load_end"}, VOICE_LOAD, '0);
        check({name, "_busy_end"}, BUSY,       1'b0);
    endtask

    initial begin
        tick(2);
        check("rst_busy", BUSY, 1'b0);
        check("rst_gate", VOICE_GATE, 4'b0000);
        check("rst_note", VOICE_NOTE, 32'h0);
        check("rst_load", VOICE_LOAD, 4'b0000);
        check("rst_ovf",  OVERFLOW, 1'b0);
        RST_N = 1'b1;
        tick(2);

        // Fill all four voices in order, then steal the two oldest.
        note_on("first_on", 24'h903C40, 4'b0001, 1'b0, 4'b0001, 32'h0000003C);
        note_on("on_3e",    24'h903E40, 4'b0010, 1'b0, 4'b0011, 32'h00003E3C);
        note_on("on_40",    24'h904040, 4'b0100, 1'b0, 4'b0111, 32'h00403E3C);
        note_on("on_41",    24'h904140, 4'b1000, 1'b0, 4'b1111, 32'h41403E3C);
        note_on("steal_v0", 24'h904340, 4'b0001, 1'b1, 4'b1111, 32'h41403E43);
        note_on("steal_v1", 24'h904540, 4'b0010, 1'b1, 4'b1111, 32'h41404543);

        // Note-off via velocity 0 releases voice 0 only.
        send(24'h904300);
        tick(N + 2);
        check("off_gate", VOICE_GATE, 4'b1110);
        check("off_load", VOICE_LOAD, 4'b0000);
        check("off_note", VOICE_NOTE, 32'h41404543);

        note_on("refill_v0",  24'h903C7F, 4'b0001, 1'b0, 4'b1111, 32'h4140453C);
        note_on("retrig_v0",  24'h903C50, 4'b0001, 1'b0, 4'b1111, 32'h4140453C);
        note_on("retrig_v2",  24'h904060, 4'b0100, 1'b0, 4'b1111, 32'h4140453C);
        note_on("steal_v3",   24'h904710, 4'b1000, 1'b1, 4'b1111, 32'h4740453C);

        // Three back-to-back strobes: third is dropped.
        @(negedge CLK);
        MIDI_MSG = 24'h804700;
        MIDI_MSG_RDY = 1'b1;
        @(negedge CLK);
        MIDI_MSG = 24'hB07B00;
        @(negedge CLK);
        MIDI_MSG = 24'h903040;
        @(negedge CLK);
        MIDI_MSG_RDY = 1'b0;
        check("ovf_pulse", OVERFLOW, 1'b1);
        tick(1);
        check("ovf_end", OVERFLOW, 1'b0);
        tick(3);
        check("ovf_first_gate", VOICE_GATE, 4'b0111);
        tick(6);
        check("all_off_gate", VOICE_GATE, 4'b0000);
        tick(6);
        check("dropped_gate", VOICE_GATE, 4'b0000);
        check("dropped_busy", BUSY, 1'b0);

        // Foreign channel: ignored, but with full fixed latency.
        send(24'h913C40);
        tick(1);
        check("ign_busy1", BUSY, 1'b1);
        tick(4);
        check("ign_busy5", BUSY, 1'b1);
        tick(1);
        check("ign_busy6", BUSY, 1'b0);
        check("ign_gate",  VOICE_GATE, 4'b0000);
        check("ign_load",  VOICE_LOAD, 4'b0000);

        note_on("lowest_free", 24'h903C40, 4'b0001, 1'b0, 4'b0001, 32'h4740453C);

        // Reset during SCAN with a second message pending.
        @(negedge CLK);
        MIDI_MSG = 24'h905040;
        MIDI_MSG_RDY = 1'b1;
        @(negedge CLK);
        MIDI_MSG = 24'h905240;
        @(negedge CLK);
        MIDI_MSG_RDY = 1'b0;
        tick(2);
        check("pre_rst_busy", BUSY, 1'b1);
        #1 RST_N = 1'b0;
        #1;
        check("mid_rst_busy", BUSY, 1'b0);
        check("mid_rst_gate", VOICE_GATE, 4'b0000);
        check("mid_rst_note", VOICE_NOTE, 32'h0);
        tick(2);
        RST_N = 1'b1;
        tick(14);
        check("post_rst_gate", VOICE_GATE, 4'b0000);
        check("post_rst_busy", BUSY, 1'b0);

        note_on("after_rst", 24'h903C40, 4'b0001, 1'b0, 4'b0001, 32'h0000003C);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
